// File: rtl/maze_pkg.sv
// maze_pkg: shared direction/state types, step deltas and direction helper for the maze solver
package maze_pkg;
  typedef enum logic [1:0] {DIR_N, DIR_E, DIR_S, DIR_W} dir_t;
  typedef enum logic [3:0] {IDLE, MARK, CHECK, PROBE, EVAL, NEXT, BACK, DRAIN, DONE, FAIL} state_t;
  localparam int DX [4] = '{0, 1, 0, -1};
  localparam int DY [4] = '{-1, 0, 1, 0};
  function automatic dir_t opposite(dir_t d);
    return dir_t'(d ^ 2'd2);
  endfunction
endpackage

// File: rtl/maze_path_stack.sv
// maze_path_stack: LIFO of move directions with a combinational indexed read port for path drain
module maze_path_stack
  import maze_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int SPW = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           push,
  input  logic           pop,
  input  dir_t           din,
  input  logic [SPW-1:0] idx,
  output dir_t           top,
  output dir_t           rd_data,
  output logic [SPW-1:0] sp,
  output logic           empty,
  output logic           full
);
  localparam int AW = $clog2(DEPTH);
  dir_t mem [DEPTH];
  // stack pointer: cleared per search, moves one entry per push or pop
  always_ff @(posedge clk or posedge rst)
    if (rst) sp <= '0;
    else sp <= clear ? '0 : push ? sp + SPW'(1) : pop ? sp - SPW'(1) : sp;
  // entry storage needs no reset; only entries below sp are ever read
  always_ff @(posedge clk)
    if (push) mem[AW'(sp)] <= din;
  assign empty = sp == '0;
  assign full = sp == SPW'(DEPTH);
  assign top = empty ? DIR_N : mem[AW'(sp - SPW'(1))];
  assign rd_data = mem[AW'(idx)];
endmodule

// File: rtl/maze_dfs_engine.sv
// maze_dfs_engine: depth-first maze solver streaming the found path; MAZE_STEP_COUNT_EN adds a step counter
module maze_dfs_engine #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int XW = $clog2(COLS),
  parameter int YW = $clog2(ROWS),
  parameter int STACK_DEPTH = 256,
  parameter int SPW = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] start_x,
  input  logic [YW-1:0] start_y,
  input  logic [XW-1:0] goal_x,
  input  logic [YW-1:0] goal_y,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [XW-1:0] mem_x,
  output logic [YW-1:0] mem_y,
  output logic          mem_din,
  input  logic          mem_dout,
  output logic          path_valid,
  input  logic          path_ready,
  output logic [1:0]    path_dir,
  output logic          path_last,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic          overflow
`ifdef MAZE_STEP_COUNT_EN
  ,output logic [15:0]  steps
`endif
);
  import maze_pkg::*;
  state_t state, state_n;
  logic [XW-1:0] cx, gx, nx;
  logic [YW-1:0] cy, gy, ny;
  logic [SPW-1:0] sp, di;
  dir_t dir, mv, top, rd_data;
  logic ovf, off, at_goal, last, hs, push, pop, clear, empty, full;
  maze_path_stack #(.DEPTH(STACK_DEPTH), .SPW(SPW)) u_stack (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop), .din(dir),
    .idx(di), .top(top), .rd_data(rd_data), .sp(sp), .empty(empty), .full(full)
  );
  // a forward move steps along dir; a backtrack steps against the popped move
  assign mv = state == BACK ? opposite(top) : dir;
  assign nx = cx + XW'(DX[mv]);
  assign ny = cy + YW'(DY[mv]);
  assign off = (dir == DIR_N && cy == '0) || (dir == DIR_E && cx == XW'(COLS - 1)) ||
               (dir == DIR_S && cy == YW'(ROWS - 1)) || (dir == DIR_W && cx == '0);
  assign at_goal = cx == gx && cy == gy;
  assign last = di == sp - SPW'(1);
  assign hs = path_valid && path_ready;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next-state and per-state memory/stack strobes
  always_comb begin
    state_n = state;
    push = 1'b0;
    pop = 1'b0;
    clear = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    case (state)
      IDLE, DONE, FAIL: begin
        clear = start;
        state_n = start ? MARK : state;
      end
      MARK: begin
        mem_wr = 1'b1;
        state_n = CHECK;
      end
      CHECK: state_n = at_goal ? (empty ? DONE : DRAIN) : PROBE;
      PROBE: begin
        mem_rd = !off;
        state_n = off ? NEXT : EVAL;
      end
      EVAL: begin
        push = !mem_dout && !full;
        state_n = mem_dout ? NEXT : full ? FAIL : MARK;
      end
      NEXT: state_n = dir == DIR_W ? BACK : PROBE;
      BACK: begin
        pop = !empty;
        state_n = empty ? FAIL : top == DIR_W ? BACK : PROBE;
      end
      DRAIN: state_n = hs && last ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  // position, goal, probe direction, drain index and overflow flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cx <= '0;
      cy <= '0;
      gx <= '0;
      gy <= '0;
      dir <= DIR_N;
      di <= '0;
      ovf <= 1'b0;
    end else begin
      if (clear) begin
        cx <= start_x;
        cy <= start_y;
        gx <= goal_x;
        gy <= goal_y;
        ovf <= 1'b0;
      end
      if (push || pop) begin
        cx <= nx;
        cy <= ny;
      end
      if (state == MARK) dir <= DIR_N;
      if (state == NEXT) dir <= dir_t'(dir + 2'd1);
      if (pop) dir <= dir_t'(top + 2'd1);
      if (state == EVAL && !mem_dout && full) ovf <= 1'b1;
      di <= state == DRAIN ? di + SPW'(hs) : '0;
    end
`ifdef MAZE_STEP_COUNT_EN
  // saturating count of pushes and pops for the current search
  always_ff @(posedge clk or posedge rst)
    if (rst) steps <= '0;
    else if (clear) steps <= '0;
    else if ((push || pop) && steps != 16'hFFFF) steps <= steps + 16'd1;
`endif
  assign mem_x = state == MARK ? cx : state == PROBE && !off ? nx : '0;
  assign mem_y = state == MARK ? cy : state == PROBE && !off ? ny : '0;
  assign mem_din = 1'b1;
  assign path_valid = state == DRAIN;
  assign path_dir = path_valid ? rd_data : 2'd0;
  assign path_last = path_valid && last;
  assign busy = !(state == IDLE || state == DONE || state == FAIL);
  assign done = state == DONE;
  assign fail = state == FAIL;
  assign overflow = ovf;
endmodule
